// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit.
// Holds the divider state encoding, the operand width and the iteration count.
package mdu_pkg;

    localparam int DIV_W     = 32;
    localparam int DIV_ITERS = 32;
    localparam int DIV_CNT_W = $clog2(DIV_ITERS);

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIX,
        DONE
    } div_state_t;

    // Magnitude of v when en is set and v is negative, otherwise v unchanged.
    function automatic logic [DIV_W-1:0] abs_if(input logic [DIV_W-1:0] v, input logic en);
        return (en && v[DIV_W-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// Execute-stage divider handshake: the pipeline drives requests (master),
// the divider returns the stall request and the result (slave).
interface div_unit_if;

    logic                       div_start;
    logic                       div_signed;
    logic [mdu_pkg::DIV_W-1:0]  div_a;
    logic [mdu_pkg::DIV_W-1:0]  div_b;
    logic                       flush;
    logic                       e_advance;
    logic                       div_pending;
    logic                       result_valid;
    logic [mdu_pkg::DIV_W-1:0]  quotient;
    logic [mdu_pkg::DIV_W-1:0]  remainder;

    modport master (
        output div_start, div_signed, div_a, div_b, flush, e_advance,
        input  div_pending, result_valid, quotient, remainder
    );

    modport slave (
        input  div_start, div_signed, div_a, div_b, flush, e_advance,
        output div_pending, result_valid, quotient, remainder
    );

endinterface

// File: rtl/div_iter.sv
// One radix-2 restoring division step: shift {rem, quo} left, trial-subtract
// the divisor, keep the difference and set the quotient LSB when it does not borrow.
module div_iter
    import mdu_pkg::*;
(
    input  logic [DIV_W-1:0] rem_i,
    input  logic [DIV_W-1:0] quo_i,
    input  logic [DIV_W-1:0] dvsr_i,
    output logic [DIV_W-1:0] rem_o,
    output logic [DIV_W-1:0] quo_o
);

    logic [DIV_W:0] shifted;
    logic [DIV_W:0] diff;

    always_comb begin
        shifted = {rem_i, quo_i[DIV_W-1]};
        diff    = shifted - {1'b0, dvsr_i};
        // The partial remainder stays below the divisor, so bit DIV_W of diff is the borrow.
        if (diff[DIV_W]) begin
            rem_o = shifted[DIV_W-1:0];
            quo_o = {quo_i[DIV_W-2:0], 1'b0};
        end else begin
            rem_o = diff[DIV_W-1:0];
            quo_o = {quo_i[DIV_W-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit DIV/DIVU unit (restoring, one bit per cycle) with pipeline stall output.
// Optional build macro DIV_EARLY_OUT_EN skips the iterations when b=0 or |a|<|b|.
module div_unit
    import mdu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  bus
);

    div_state_t             state_q;
    logic [DIV_W-1:0]       a_q;
    logic [DIV_W-1:0]       b_q;
    logic                   signed_q;
    logic                   neg_quo_q;
    logic                   neg_rem_q;
    logic [DIV_W-1:0]       dvsr_q;
    logic [DIV_W-1:0]       rem_q;
    logic [DIV_W-1:0]       quo_q;
    logic [DIV_CNT_W-1:0]   cnt_q;
    logic                   result_valid_q;
    logic [DIV_W-1:0]       quotient_q;
    logic [DIV_W-1:0]       remainder_q;

    logic [DIV_W-1:0]       rem_d;
    logic [DIV_W-1:0]       quo_d;
    logic [DIV_W-1:0]       a_mag;
    logic [DIV_W-1:0]       b_mag;
    logic [DIV_W-1:0]       fix_quo;
    logic [DIV_W-1:0]       fix_rem;

    div_iter u_div_iter (
        .rem_i  (rem_q),
        .quo_i  (quo_q),
        .dvsr_i (dvsr_q),
        .rem_o  (rem_d),
        .quo_o  (quo_d)
    );

    assign a_mag = abs_if(a_q, signed_q);
    assign b_mag = abs_if(b_q, signed_q);

    // NOTE: every variable gets a value on every path through always_comb, otherwise a latch is inferred.
    always_comb begin
        fix_quo = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
        fix_rem = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
        if (b_q == '0) begin
            fix_quo = '1;
            fix_rem = a_q;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    // NOTE: operand/datapath registers carry no reset; they are always loaded before they are read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            result_valid_q <= 1'b0;
            quotient_q     <= '0;
            remainder_q    <= '0;
        end else if (bus.flush) begin
            state_q        <= IDLE;
            result_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.div_start) begin
                        a_q      <= bus.div_a;
                        b_q      <= bus.div_b;
                        signed_q <= bus.div_signed;
                        state_q  <= PREP;
                    end
                end
                PREP: begin
                    neg_quo_q <= signed_q & (a_q[DIV_W-1] ^ b_q[DIV_W-1]);
                    neg_rem_q <= signed_q & a_q[DIV_W-1];
                    dvsr_q    <= b_mag;
                    cnt_q     <= DIV_CNT_W'(DIV_ITERS - 1);
`ifdef DIV_EARLY_OUT_EN
                    if ((b_q == '0) || (a_mag < b_mag)) begin
                        rem_q   <= a_mag;
                        quo_q   <= '0;
                        state_q <= FIX;
                    end else begin
                        rem_q   <= '0;
                        quo_q   <= a_mag;
                        state_q <= ITER;
                    end
`else
                    rem_q   <= '0;
                    quo_q   <= a_mag;
                    state_q <= ITER;
`endif
                end
                ITER: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q - DIV_CNT_W'(1);
                    if (cnt_q == '0) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    quotient_q     <= fix_quo;
                    remainder_q    <= fix_rem;
                    result_valid_q <= 1'b1;
                    state_q        <= DONE;
                end
                DONE: begin
                    // div_start is deliberately ignored here: the same instruction is still in E.
                    if (bus.e_advance) begin
                        result_valid_q <= 1'b0;
                        state_q        <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.div_pending  = ~rst & (((state_q == IDLE) & bus.div_start & ~bus.flush) |
                                      (state_q == PREP) | (state_q == ITER) | (state_q == FIX));
    assign bus.result_valid = result_valid_q;
    assign bus.quotient     = quotient_q;
    assign bus.remainder    = remainder_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: a cycle-level latency/result model checked every cycle,
// plus hand-computed expectations for each directed divide.
module tb_div_unit;
    import mdu_pkg::*;

`ifdef DIV_EARLY_OUT_EN
    localparam int LAT_EZ = 3;
`else
    localparam int LAT_EZ = 35;
`endif
    localparam int LAT_FULL = 35;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_unit_if bus();

    div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference results from plain integer arithmetic (64-bit avoids the INT_MIN/-1 overflow).
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                    output logic [31:0] q, output logic [31:0] r);
        longint sa, sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Cycles from acceptance to result_valid.
    function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input logic s);
`ifdef DIV_EARLY_OUT_EN
        logic [31:0] ma, mb;
        ma = (s && a[31]) ? -a : a;
        mb = (s && b[31]) ? -b : b;
        if (b == 32'd0 || ma < mb) return 3;
`endif
        return (s || !s) ? LAT_FULL : LAT_FULL;
    endfunction

    // Model: k = cycles since acceptance (-1 when idle); results appear at k == lat.
    int          k = -1;
    int          lat = LAT_FULL;
    bit          mdl_init = 1'b0;
    logic [31:0] mq, mr, nq, nr;
    logic        exp_pend, exp_rv;

    always @(negedge clk) begin
        if (mdl_init) begin
            if (rst)        exp_pend = 1'b0;
            else if (k < 0) exp_pend = bus.div_start & ~bus.flush;
            else            exp_pend = (k < lat);
            exp_rv = (k >= lat);
            check("div_pending",  {31'd0, bus.div_pending},  {31'd0, exp_pend});
            check("result_valid", {31'd0, bus.result_valid}, {31'd0, exp_rv});
            check("quotient",     bus.quotient,  mq);
            check("remainder",    bus.remainder, mr);
        end
        if (rst) begin
            k = -1; mq = '0; mr = '0; mdl_init = 1'b1;
        end else if (bus.flush) begin
            k = -1;
        end else if (k < 0) begin
            if (bus.div_start) begin
                k   = 1;
                lat = ref_lat(bus.div_a, bus.div_b, bus.div_signed);
                ref_div(bus.div_a, bus.div_b, bus.div_signed, nq, nr);
            end
        end else if (k < lat) begin
            k++;
            if (k == lat) begin
                mq = nq;
                mr = nr;
            end
        end else if (bus.e_advance) begin
            k = -1;
        end
    end

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [31:0] eq, input logic [31:0] er, input int elat,
                           input int hold, input string tag);
        int n = 0;
        @(posedge clk); #1;
        bus.div_start  = 1'b1;
        bus.div_a      = a;
        bus.div_b      = b;
        bus.div_signed = s;
        @(negedge clk);
        while (!bus.result_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"},   n, elat);
        check({tag, " quotient"},  bus.quotient, eq);
        check({tag, " remainder"}, bus.remainder, er);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            bus.e_advance = 1'b0;
            @(negedge clk);
            check({tag, " hold valid"},     {31'd0, bus.result_valid}, 32'd1);
            check({tag, " hold pending"},   {31'd0, bus.div_pending},  32'd0);
            check({tag, " hold quotient"},  bus.quotient,  eq);
            check({tag, " hold remainder"}, bus.remainder, er);
        end
        @(posedge clk); #1;
        bus.e_advance = 1'b1;
        @(posedge clk); #1;
        bus.div_start = 1'b0;
        bus.e_advance = 1'b0;
        @(negedge clk);
        check({tag, " idle valid"}, {31'd0, bus.result_valid}, 32'd0);
    endtask

    initial begin
        rst            = 1'b1;
        bus.div_start  = 1'b0;
        bus.div_signed = 1'b0;
        bus.div_a      = '0;
        bus.div_b      = '0;
        bus.flush      = 1'b0;
        bus.e_advance  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset valid",     {31'd0, bus.result_valid}, 32'd0);
        check("reset quotient",  bus.quotient,  32'd0);
        check("reset remainder", bus.remainder, 32'd0);

        run_div(32'd100,       32'd7,         1'b0, 32'd14,        32'd2,         LAT_FULL, 0, "divu 100/7");
        run_div(32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, LAT_FULL, 0, "div -7/2");
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0,         LAT_FULL, 0, "div min/-1");
        run_div(32'h0000_1234, 32'd0,         1'b0, 32'hFFFF_FFFF, 32'h0000_1234, LAT_EZ,   0, "divu x/0");
        run_div(32'h8000_0005, 32'd0,         1'b1, 32'hFFFF_FFFF, 32'h8000_0005, LAT_EZ,   0, "div neg/0");
        run_div(32'd5,         32'd9,         1'b0, 32'd0,         32'd5,         LAT_EZ,   0, "divu 5/9");
        run_div(32'hFFFF_FFFB, 32'd9,         1'b1, 32'd0,         32'hFFFF_FFFB, LAT_EZ,   0, "div -5/9");

        // Flush ten cycles after acceptance; nothing may complete.
        @(posedge clk); #1;
        bus.div_start  = 1'b1;
        bus.div_a      = 32'd100;
        bus.div_b      = 32'd7;
        bus.div_signed = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        bus.flush     = 1'b1;
        bus.div_start = 1'b0;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        @(negedge clk);
        check("flush pending", {31'd0, bus.div_pending},  32'd0);
        check("flush valid",   {31'd0, bus.result_valid}, 32'd0);
        repeat (40) @(negedge clk);
        run_div(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, LAT_FULL, 0, "divu 9/3");

        run_div(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, LAT_FULL, 3, "div 7/-2 stall");

        // Reset twenty cycles into a divide.
        @(posedge clk); #1;
        bus.div_start  = 1'b1;
        bus.div_a      = 32'd1000;
        bus.div_b      = 32'd3;
        bus.div_signed = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst           = 1'b1;
        bus.div_start = 1'b0;
        @(negedge clk);
        check("rst pending", {31'd0, bus.div_pending}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post-rst pending",   {31'd0, bus.div_pending},  32'd0);
        check("post-rst valid",     {31'd0, bus.result_valid}, 32'd0);
        check("post-rst quotient",  bus.quotient,  32'd0);
        check("post-rst remainder", bus.remainder, 32'd0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit integer divider for the execute stage. It serves DIV/DIVU with radix-2 restoring division and produces the quotient (LO) and remainder (HI). It drives the divide-pending stall into the pipeline control/hazard unit, which holds fetch, decode and execute and bubbles memory while the divide runs. Results are handed to the E→M pipeline register when the execute stage advances.

## Interface
- No parameters; widths are fixed by package constants.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- div_start  in  1  a DIV/DIVU instruction occupies the execute stage.
  - Held high for as long as that instruction remains in E.
- div_signed  in  1  1 = DIV (signed), 0 = DIVU; sampled with div_start.
- div_a  in  32  dividend (rs); latched on acceptance.
- div_b  in  32  divisor (rt); latched on acceptance.
- flush  in  1  exception or pipeline flush of E; aborts any operation.
- e_advance  in  1  the E→M register captures this cycle, i.e. E is not stalled.
- div_pending  out  1  stall request to the hazard unit; combinational.
- result_valid  out  1  quotient and remainder are final.
- quotient  out  32  goes to LO.
- remainder  out  32  goes to HI.

## Operation
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE:
  - Accepts when div_start=1 and flush=0.
  - Latches operands and div_signed, then goes to PREP.
- PREP:
  - Forms absolute values when signed.
  - Records sign_q = a[31]^b[31] and sign_r = a[31].
  - Clears the partial remainder and loads the counter with 31.
  - Next state is ITER.
- ITER, one restoring step per cycle:
  - Shift {rem, quo} left by 1.
  - Trial subtract the divisor.
  - On no borrow, keep the difference and set the quotient LSB.
  - Leave after the step with counter = 0, which is 32 steps in total.
- FIX:
  - Negates the quotient if sign_q and the remainder if sign_r (signed only).
  - Then applies the divide-by-zero override.
  - Goes to DONE.
- Divide-by-zero (b=0): quotient = 32'hFFFFFFFF and remainder = a, for both signed and unsigned, in every configuration.
- Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0. This is two's-complement wrap; no trap.
- DONE:
  - result_valid=1 and outputs are held.
  - On e_advance goes to IDLE.
  - div_start is ignored in DONE, so there is no restart while the same instruction is still in E.
- div_pending = (IDLE & div_start & ~flush) | PREP | ITER | FIX. It is 0 in DONE so E can advance.
- flush in any state:
  - Next state is IDLE and result_valid is 0 the next cycle.
  - Takes priority over e_advance and over acceptance.
- rst takes priority over everything. After rst:
  - state = IDLE
  - div_pending = 0 while rst is high
  - result_valid = 0
  - quotient = remainder = 0
- quotient/remainder change only in FIX or on reset. They are not cleared on flush but are meaningless when result_valid=0.

## Timing
- Acceptance cycle T (IDLE): div_pending=1 combinationally.
- Cycle sequence:
  - PREP at T+1
  - ITER at T+2..T+33
  - FIX at T+34
  - DONE at T+35
- div_pending is high for T..T+34, 35 cycles. result_valid rises at T+35.
- If e_advance=1 at T+35, IDLE is at T+36. Back-to-back divides are accepted at T+36.
- A flush at cycle F gives state IDLE at F+1. div_pending drops in cycle F if the state is IDLE.

## Configuration
- DIV_EARLY_OUT_EN:
  - Defined: in PREP, if b=0 or |a|<|b| (unsigned compare of the magnitudes), skip ITER and go to FIX. The quotient is 0 and the remainder is the magnitude of a, restored to the sign of a in FIX; the b=0 override still applies. div_pending is high T..T+2 and result_valid rises at T+3.
  - Undefined: every divide takes the full 35 pending cycles.
- Results are bit-identical in both configurations.

## Structure
- Package mdu_pkg holds:
  - the div_state_t enum (IDLE, PREP, ITER, FIX, DONE)
  - DIV_W=32 and DIV_ITERS=32
  - the counter width localparam
- Sub-module div_iter is a combinational single restoring step: in {rem, quo, divisor}, out {rem', quo'}. div_unit instantiates it once.

## Test plan
- DIVU 100/7:
  - quotient=14, remainder=2.
  - div_pending high exactly 35 cycles and result_valid at T+35.
  - With DIV_EARLY_OUT_EN the latency is unchanged.
- DIV 0xFFFFFFF9 (−7) / 2 → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0.
- DIVU 0x1234 / 0 → quotient=0xFFFFFFFF, remainder=0x00001234. result_valid is at T+3 with DIV_EARLY_OUT_EN and at T+35 without it.
- flush at T+10:
  - div_pending=0 and state IDLE at T+11; result_valid never rises.
  - A new DIVU 9/3 then gives 3 remainder 0.
- e_advance held low for 3 cycles in DONE with div_start still high:
  - result_valid and outputs stay stable and div_pending stays 0.
  - IDLE follows the cycle after e_advance.
- rst asserted at T+20 → all outputs 0 the next cycle.
